i2s2_tx: RTL and testbench

//   I2S transmitter for the I2S2 PMOD DAC path.
//   - Takes parallel stereo samples on a valid/ready interface and serialises them onto tx_data.
//   - Generates tx_mclk/tx_lrck/tx_sclk with the same divider scheme as the passthrough:

---
 rtl/i2s2_tx.sv | 130 +++++++++++++
 tb/tb_i2s2_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s2_tx.sv
// i2s2_tx: I2S transmitter for the I2S2 PMOD DAC path.
// Accepts stereo sample pairs on a valid/ready interface into a single
// holding register, loads them into the frame registers at each frame start
// (count 511->0) and shifts them out MSB first with the I2S one-bit delay.
// Clocks: mclk = clk, sclk = count[2] (clk/8), lrck = count[8] (clk/512).
//
// Handshake: a pair is transferred on any rising clk edge where
// s_valid && s_ready. s_ready is high exactly while the holding register is
// empty. While s_ready is low, s_left/s_right/s_valid are ignored.
module i2s2_tx #(
   parameter int DATA_WIDTH      = 24,
   parameter bit UNDERRUN_REPEAT = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_left,
   input  logic [DATA_WIDTH-1:0] s_right,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  tx_mclk,
   output logic                  tx_lrck,
   output logic                  tx_sclk,
   output logic                  tx_data,
   output logic                  underrun,
   output logic [15:0]           underrun_cnt
);

   logic [8:0]            r_count;
   logic                  r_hold_full;
   logic [DATA_WIDTH-1:0] r_hold_l;
   logic [DATA_WIDTH-1:0] r_hold_r;
   logic [DATA_WIDTH-1:0] r_frame_l;
   logic [DATA_WIDTH-1:0] r_frame_r;
   logic                  r_tx_data;
   logic                  r_underrun;
   logic [15:0]           r_underrun_cnt;

   logic [8:0]            w_count_next;
   logic                  w_frame_start;
   logic                  w_accept;
   logic                  w_bit_edge;
   logic [4:0]            w_slot;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_bit;

   assign w_count_next  = r_count + 9'd1;
   assign w_frame_start = (r_count == 9'd511);
   assign w_accept      = s_valid & ~r_hold_full;
   // sclk falling edge: count[2:0] wraps 7->0
   assign w_bit_edge    = (r_count[2:0] == 3'd7);

   // Free-running 9-bit timing counter, wraps 511->0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 9'd0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // Holding register, frame load at frame start, and underrun tracking.
   // Accept and frame-load never coincide: accept needs the hold empty,
   // a load needs it full, so a pair arriving on the frame start edge
   // simply lands in the hold and plays in the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_full    <= 1'b0;
         r_hold_l       <= '0;
         r_hold_r       <= '0;
         r_frame_l      <= '0;
         r_frame_r      <= '0;
         r_underrun     <= 1'b0;
         r_underrun_cnt <= 16'd0;
      end else begin
         r_underrun <= 1'b0;
         if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_l    <= s_left;
            r_hold_r    <= s_right;
         end
         if (w_frame_start) begin
            if (r_hold_full) begin
               r_frame_l   <= r_hold_l;
               r_frame_r   <= r_hold_r;
               r_hold_full <= 1'b0;
            end else begin
               r_underrun <= 1'b1;
               if (r_underrun_cnt != 16'hFFFF) begin
                  r_underrun_cnt <= r_underrun_cnt + 16'd1;
               end
               if (!UNDERRUN_REPEAT) begin
                  r_frame_l <= '0;
                  r_frame_r <= '0;
               end
            end
         end
      end
   end

   // Pick the bit for the slot/channel about to start: slot 0 is the
   // one-bit delay, slots 1..DATA_WIDTH carry MSB..LSB, the rest pad with 0.
   always_comb begin
      w_slot = w_count_next[7:3];
      w_word = w_count_next[8] ? r_frame_r : r_frame_l;
      w_bit  = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (int'(w_slot) == DATA_WIDTH - i) begin
            w_bit = w_word[i];
         end
      end
   end

   // Serial data register, updated only on the sclk falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_data <= 1'b0;
      end else if (w_bit_edge) begin
         r_tx_data <= w_bit;
      end
   end

   assign s_ready      = ~r_hold_full;
   assign tx_mclk      = clk;
   assign tx_lrck      = r_count[8];
   assign tx_sclk      = r_count[2];
   assign tx_data      = r_tx_data;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s2_tx.sv
// tb_i2s2_tx: self-checking bench for i2s2_tx. Two instances share the
// stimulus: dut0 (underrun sends zeros) and dut1 (underrun repeats).
// A frame-level reference model (position in frame, pending-pair queue,
// per-frame sample words) predicts every output each cycle; a table of
// hand-derived points checks one known frame, and short sequences cover
// the starve, frame-edge transfer, mid-frame reset and saturation cases.
module tb_i2s2_tx;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_left = '0;
   logic [DW-1:0] s_right = '0;
   logic          s_valid = 1'b0;

   logic [1:0]    w_ready, w_mclk, w_lrck, w_sclk, w_data, w_urun;
   logic [15:0]   w_ucnt0, w_ucnt1;

   i2s2_tx #(.DATA_WIDTH(DW), .UNDERRUN_REPEAT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .s_left(s_left), .s_right(s_right),
      .s_valid(s_valid), .s_ready(w_ready[0]), .tx_mclk(w_mclk[0]),
      .tx_lrck(w_lrck[0]), .tx_sclk(w_sclk[0]), .tx_data(w_data[0]),
      .underrun(w_urun[0]), .underrun_cnt(w_ucnt0));

   i2s2_tx #(.DATA_WIDTH(DW), .UNDERRUN_REPEAT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .s_left(s_left), .s_right(s_right),
      .s_valid(s_valid), .s_ready(w_ready[1]), .tx_mclk(w_mclk[1]),
      .tx_lrck(w_lrck[1]), .tx_sclk(w_sclk[1]), .tx_data(w_data[1]),
      .underrun(w_urun[1]), .underrun_cnt(w_ucnt1));

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model state
   int               m_cnt;
   logic [2*DW-1:0]  hold_q[$];
   logic [DW-1:0]    m_fl[2];
   logic [DW-1:0]    m_fr[2];
   logic [15:0]      m_ucnt[2];
   logic             m_urun;
   bit               m_acc;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int   cnt;
      logic data;
      logic lrck;
      logic sclk;
      logic ready;
   } row_t;
   row_t tbl[16];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[dut%0d] t=%0t pos=%0d: got %0h expected %0h", name, k, $time, m_cnt, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [DW-1:0] l, input logic [DW-1:0] r, input int c);
      int p, s;
      logic [DW-1:0] w;
      p = c / 8;
      s = p % 32;
      w = (p >= 32) ? r : l;
      if (s == 0 || s > DW) return 1'b0;
      return w[DW-s];
   endfunction

   task automatic check_all();
      logic [15:0] uc;
      for (int k = 0; k < 2; k++) begin
         uc = (k == 0) ? w_ucnt0 : w_ucnt1;
         chk("s_ready", k, w_ready[k], hold_q.size() == 0);
         chk("underrun", k, w_urun[k], m_urun);
         chk("underrun_cnt", k, uc, m_ucnt[k]);
         chk("tx_mclk", k, w_mclk[k], clk);
         chk("tx_lrck", k, w_lrck[k], m_cnt >= 256);
         chk("tx_sclk", k, w_sclk[k], (m_cnt % 8) >= 4);
         chk("tx_data", k, w_data[k], exp_bit(m_fl[k], m_fr[k], m_cnt));
      end
   endtask

   // driver: advance one clock, model the edge, then check
   task automatic step();
      logic [2*DW-1:0] pair;
      m_acc  = s_valid && (hold_q.size() == 0);
      m_urun = 1'b0;
      if (m_cnt == 511) begin
         if (hold_q.size() != 0) begin
            pair = hold_q.pop_front();
            for (int k = 0; k < 2; k++) begin
               m_fl[k] = pair[2*DW-1:DW];
               m_fr[k] = pair[DW-1:0];
            end
         end else begin
            m_urun = 1'b1;
            for (int k = 0; k < 2; k++)
               if (m_ucnt[k] != 16'hFFFF) m_ucnt[k] = m_ucnt[k] + 16'd1;
            m_fl[0] = '0;
            m_fr[0] = '0;
         end
      end
      if (m_acc) hold_q.push_back({s_left, s_right});
      m_cnt = (m_cnt + 1) % 512;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // at least one step, then until the frame position equals c (<=512 steps)
   task automatic run_to(input int c);
      do step(); while (m_cnt != c);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      m_cnt = 0;
      hold_q.delete();
      m_urun = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_fl[k] = '0;
         m_fr[k] = '0;
         m_ucnt[k] = 16'd0;
      end
      check_all();
   endtask

   initial begin
      logic [31:0] rnd;
      int n_xfer;
      // frame with L=ABCDEF R=123456: {count, tx_data, lrck, sclk, s_ready}
      tbl = '{
         '{0,   1'b0, 1'b0, 1'b0, 1'b1},
         '{4,   1'b0, 1'b0, 1'b1, 1'b1},
         '{7,   1'b0, 1'b0, 1'b1, 1'b1},
         '{8,   1'b1, 1'b0, 1'b0, 1'b1},
         '{16,  1'b0, 1'b0, 1'b0, 1'b1},
         '{24,  1'b1, 1'b0, 1'b0, 1'b1},
         '{64,  1'b1, 1'b0, 1'b0, 1'b1},
         '{192, 1'b1, 1'b0, 1'b0, 1'b1},
         '{200, 1'b0, 1'b0, 1'b0, 1'b1},
         '{256, 1'b0, 1'b1, 1'b0, 1'b1},
         '{264, 1'b0, 1'b1, 1'b0, 1'b1},
         '{288, 1'b1, 1'b1, 1'b0, 1'b1},
         '{300, 1'b0, 1'b1, 1'b1, 1'b1},
         '{440, 1'b1, 1'b1, 1'b0, 1'b1},
         '{448, 1'b0, 1'b1, 1'b0, 1'b1},
         '{511, 1'b0, 1'b1, 1'b1, 1'b1}
      };

      // 1: idle after reset -> underrun every 512 cycles
      do_reset(10);
      run(3 * 512);
      chk("ucnt_after_3_frames", 0, w_ucnt0, 32'd3);
      chk("ucnt_after_3_frames", 1, w_ucnt1, 32'd3);

      // 2: one known pair, table of serial points
      do_reset(10);
      run(5);
      s_left = 24'hABCDEF;
      s_right = 24'h123456;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      run_to(0);
      for (int c = 0; c < 512; c++) begin
         if (c > 0) step();
         for (int i = 0; i < 16; i++) begin
            if (tbl[i].cnt == c) begin
               for (int k = 0; k < 2; k++) begin
                  chk("tbl_data", k, w_data[k], tbl[i].data);
                  chk("tbl_lrck", k, w_lrck[k], tbl[i].lrck);
                  chk("tbl_sclk", k, w_sclk[k], tbl[i].sclk);
                  chk("tbl_ready", k, w_ready[k], tbl[i].ready);
               end
            end
         end
      end

      // 3: s_valid held high, incrementing pairs
      run(1);
      rnd = $urandom;
      s_left = rnd[DW-1:0];
      rnd = $urandom;
      s_right = rnd[DW-1:0];
      s_valid = 1'b1;
      n_xfer = 0;
      repeat (6 * 512) begin
         step();
         if (m_acc) begin
            n_xfer++;
            s_left = s_left + 1'b1;
            s_right = s_right + 1'b1;
         end
      end
      s_valid = 1'b0;
      chk("xfers_in_6_frames", 0, (n_xfer >= 6 && n_xfer <= 7), 32'd1);

      // random sparse traffic with underruns
      repeat (8 * 512) begin
         rnd = $urandom;
         s_left = rnd[DW-1:0];
         rnd = $urandom;
         s_right = rnd[DW-1:0];
         s_valid = ($urandom_range(0, 999) < 3);
         step();
      end
      s_valid = 1'b0;

      // 4: single pair then starve
      do_reset(3);
      run(20);
      s_left = 24'h800001;
      s_right = 24'h7FFFFE;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      run_to(0);
      run_to(0);
      chk("starve_underrun", 0, w_urun[0], 32'd1);
      chk("starve_underrun", 1, w_urun[1], 32'd1);
      run(8);
      chk("starve_msb", 0, w_data[0], 32'd0);
      chk("starve_msb", 1, w_data[1], 32'd1);
      chk("starve_ucnt", 0, w_ucnt0, 32'd1);

      // 5: one-cycle transfer exactly on the frame start edge, hold empty
      run_to(511);
      s_left = 24'hC00003;
      s_right = 24'h300005;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("edge_underrun", 0, w_urun[0], 32'd1);
      chk("edge_accepted", 0, w_ready[0], 32'd0);
      run_to(0);
      chk("edge_next_no_underrun", 0, w_urun[0], 32'd0);
      run(8);
      chk("edge_pair_msb", 0, w_data[0], 32'd1);

      // 6: reset mid right channel, then saturation
      run_to(300);
      do_reset(1);
      chk("rst_lrck", 0, w_lrck[0], 32'd0);
      chk("rst_sclk", 0, w_sclk[0], 32'd0);
      chk("rst_data", 0, w_data[0], 32'd0);
      chk("rst_ready", 0, w_ready[0], 32'd1);
      run(100);
      force dut0.r_underrun_cnt = 16'hFFFF;
      #1;
      release dut0.r_underrun_cnt;
      m_ucnt[0] = 16'hFFFF;
      run(2 * 512);
      chk("ucnt_saturated", 0, w_ucnt0, 32'h0000FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
